// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: frame FSM state
// encoding, default frame start marker and bit-timing derivation.
package imem_uart_loader_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;

    // Frame FSM encoding
    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] GET_COUNT = 3'd1;
    localparam logic [STATE_W-1:0] GET_DATA  = 3'd2;
    localparam logic [STATE_W-1:0] GET_CSUM  = 3'd3;
    localparam logic [STATE_W-1:0] DONE      = 3'd4;
    localparam logic [STATE_W-1:0] ERROR     = 3'd5;

    localparam logic [BYTE_W-1:0] START_BYTE_DEFAULT = 8'hA5;

    // Clocks per UART bit (integer division)
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx_core.sv
// uart_rx_core: 8N1 LSB-first UART receiver.
//   clk, reset   : system clock, async active-low reset
//   uart_rx      : raw serial line (idles high)
//   rx_valid     : one-cycle pulse, rx_byte holds a byte with a good stop bit
//   rx_byte      : last received byte
//   rx_ferr      : one-cycle pulse when the stop bit was sampled low
module uart_rx_core
    import imem_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              rx_valid,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_ferr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic              rx_meta, rx_sync, rx_prev;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              rx_valid_d, rx_ferr_d;
    logic [BYTE_W-1:0] rx_byte_d;

    // Synchronizer, edge history and receiver state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rx_valid <= rx_valid_d;
            rx_ferr  <= rx_ferr_d;
            rx_byte  <= rx_byte_d;
        end
    end

    // Bit timing and sampling
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_byte_d  = rx_byte;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LAST;
                end
            end
            RX_START: begin
                // Mid-start re-check rejects short glitches
                if (cnt_q == '0) begin
                    if (rx_sync) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = BIT_LAST;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync, shift_q[BYTE_W-1:1]};
                    cnt_d   = BIT_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (rx_sync) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shift_q;
                    end else begin
                        rx_ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: receives a framed program image over UART
// (START, COUNT, COUNT*4 big-endian data bytes, XOR checksum) and writes it
// word by word into instruction memory while holding the processor.
//   clk, reset  : system clock, async active-low reset
//   uart_rx     : serial line from host
//   imem_we     : one-cycle write strobe
//   imem_addr   : word address of the write
//   imem_wdata  : word to write
//   cpu_hold    : processor stall/reset request while loading or after failure
//   load_done   : last load completed with good checksum
//   load_error  : last load aborted (framing error or bad checksum)
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int unsigned       CLK_FREQ_HZ = 100000000,
    parameter int unsigned       BAUD        = 9600,
    parameter int unsigned       ADDR_WIDTH  = 8,
    parameter logic [BYTE_W-1:0] START_BYTE  = START_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

    logic              rx_valid, rx_ferr;
    logic [BYTE_W-1:0] rx_byte;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    logic [STATE_W-1:0]    state_q, state_d;
    logic [BYTE_W-1:0]     count_q, count_d;
    logic [BYTE_W-1:0]     words_q, words_d;
    logic [1:0]            idx_q, idx_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_W-1:0]     csum_q, csum_d;
    logic                  imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_d;
    logic [WORD_W-1:0]     imem_wdata_d;
    logic                  cpu_hold_d, load_done_d, load_error_d;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            words_q    <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            words_q    <= words_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            cpu_hold   <= cpu_hold_d;
            load_done  <= load_done_d;
            load_error <= load_error_d;
        end
    end

    // Frame parsing, word assembly, checksum and address counter
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        words_d      = words_q;
        idx_d        = idx_q;
        word_d       = word_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        cpu_hold_d   = cpu_hold;
        load_done_d  = load_done;
        load_error_d = load_error;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (rx_valid && (rx_byte == START_BYTE)) begin
                    state_d      = GET_COUNT;
                    cpu_hold_d   = 1'b1;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    imem_addr_d  = '0;
                    csum_d       = '0;
                    idx_d        = '0;
                    words_d      = '0;
                end
            end
            GET_COUNT: begin
                if (rx_ferr) begin
                    state_d      = ERROR;
                    load_error_d = 1'b1;
                end else if (rx_valid) begin
                    count_d = rx_byte;
                    state_d = (rx_byte == '0) ? GET_CSUM : GET_DATA;
                end
            end
            GET_DATA: begin
                // Cycle after the strobe: advance address, leave after last word
                if (imem_we) begin
                    imem_addr_d = ADDR_WIDTH'(imem_addr + 1'b1);
                    words_d     = words_q + 8'd1;
                    if (words_q == BYTE_W'(count_q - 8'd1)) begin
                        state_d = GET_CSUM;
                    end
                end
                if (rx_ferr) begin
                    state_d      = ERROR;
                    load_error_d = 1'b1;
                end else if (rx_valid) begin
                    word_d = {word_q[WORD_W-BYTE_W-1:0], rx_byte};
                    csum_d = csum_q ^ rx_byte;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {word_q[WORD_W-BYTE_W-1:0], rx_byte};
                    end
                end
            end
            GET_CSUM: begin
                if (rx_ferr) begin
                    state_d      = ERROR;
                    load_error_d = 1'b1;
                end else if (rx_valid) begin
                    if (rx_byte == csum_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d      = ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed self-checking bench for imem_uart_loader at 16 clocks per bit.
module tb_imem_uart_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold, load_done, load_error;

    localparam logic [7:0] CSUM_GOOD = 8'h20 ^ 8'h08 ^ 8'h00 ^ 8'h05 ^
                                       8'h8C ^ 8'h09 ^ 8'h00 ^ 8'h04;

    imem_uart_loader #(
        .CLK_FREQ_HZ (16),
        .BAUD        (1),
        .ADDR_WIDTH  (8),
        .START_BYTE  (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Write and receive-strobe monitor
    int          wr_total  = 0;
    int          rxv_total = 0;
    logic [7:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr[wr_total[5:0]] = imem_addr;
            wr_data[wr_total[5:0]] = imem_wdata;
            wr_total = wr_total + 1;
        end
        if (dut.u_rx.rx_valid) rxv_total = rxv_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time();
        repeat (16) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            bit_time();
        end
        uart_rx = stop;
        bit_time();
        uart_rx = 1'b1;
        if (!stop) bit_time();
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] csum);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'h20080005);
        send_word(32'h8C090004);
        send_byte(csum, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    int base;
    int rbase;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_error, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Good load
        base = wr_total;
        send_byte(8'hA5, 1'b1);
        chk("good_hold_busy", cpu_hold, 1);
        send_byte(8'h02, 1'b1);
        send_word(32'h20080005);
        send_word(32'h8C090004);
        send_byte(CSUM_GOOD, 1'b1);
        repeat (4) @(negedge clk);
        chk("good_nwr", wr_total - base, 2);
        chk("good_a0", wr_addr[base[5:0]], 0);
        chk("good_d0", wr_data[base[5:0]], 32'h20080005);
        chk("good_a1", wr_addr[6'(base + 1)], 1);
        chk("good_d1", wr_data[6'(base + 1)], 32'h8C090004);
        chk("good_addr_end", imem_addr, 2);
        chk("good_done", load_done, 1);
        chk("good_hold", cpu_hold, 0);
        chk("good_err", load_error, 0);

        // Bad checksum
        base = wr_total;
        send_frame(8'h00);
        chk("badcs_nwr", wr_total - base, 2);
        chk("badcs_err", load_error, 1);
        chk("badcs_hold", cpu_hold, 1);
        chk("badcs_done", load_done, 0);

        // Framing error on third data byte, rest of frame ignored
        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b0);
        chk("ferr_err", load_error, 1);
        chk("ferr_hold", cpu_hold, 1);
        send_byte(8'h05, 1'b1);
        send_word(32'h8C090004);
        send_byte(CSUM_GOOD, 1'b1);
        repeat (4) @(negedge clk);
        chk("ferr_nwr", wr_total - base, 0);
        chk("ferr_err_stays", load_error, 1);
        base = wr_total;
        send_frame(CSUM_GOOD);
        chk("ferr_rec_nwr", wr_total - base, 2);
        chk("ferr_rec_done", load_done, 1);
        chk("ferr_rec_err", load_error, 0);
        chk("ferr_rec_hold", cpu_hold, 0);

        // Glitch and garbage bytes while DONE
        base  = wr_total;
        rbase = rxv_total;
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        uart_rx = 1'b1;
        bit_time();
        bit_time();
        chk("glitch_rxv", rxv_total - rbase, 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        chk("garbage_rxv", rxv_total - rbase, 2);
        chk("garbage_done", load_done, 1);
        chk("garbage_hold", cpu_hold, 0);
        chk("garbage_nwr", wr_total - base, 0);

        // Zero-count frames
        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        chk("zero_nwr", wr_total - base, 0);
        chk("zero_done", load_done, 1);
        chk("zero_hold", cpu_hold, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        chk("zero_bad_err", load_error, 1);
        chk("zero_bad_hold", cpu_hold, 1);
        chk("zero_bad_done", load_done, 0);

        // Asynchronous reset during second data byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1);
        uart_rx = 1'b0;
        bit_time();
        for (int i = 0; i < 3; i++) begin
            uart_rx = 1'b0;
            bit_time();
        end
        chk("mid_hold_before", cpu_hold, 1);
        chk("mid_wdata_before", imem_wdata, 32'h8C090004);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_wdata", imem_wdata, 0);
        chk("mid_rst_hold", cpu_hold, 0);
        chk("mid_rst_done", load_done, 0);
        chk("mid_rst_err", load_error, 0);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        bit_time();
        base = wr_total;
        send_frame(CSUM_GOOD);
        chk("post_nwr", wr_total - base, 2);
        chk("post_a0", wr_addr[base[5:0]], 0);
        chk("post_d0", wr_data[base[5:0]], 32'h20080005);
        chk("post_a1", wr_addr[6'(base + 1)], 1);
        chk("post_done", load_done, 1);
        chk("post_hold", cpu_hold, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
